// File: rtl/tlb_inv_ctrl.sv
// INVTLB walker: on a legal request, walks every TLB entry once through the
// read port and clears the E bit of each entry matching the captured op/asid/vppn.
module tlb_inv_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [9:0]       asid,
    input  logic [18:0]      vppn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] r_index,
    input  logic             r_e,
    input  logic             r_g,
    input  logic [5:0]       r_ps,
    input  logic [9:0]       r_asid,
    input  logic [18:0]      r_vppn,
    output logic             inv_we,
    output logic [IDX_W-1:0] inv_index
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [4:0]       op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vppn_q;
    logic             ill_q;

    logic             walk;
    logic             asid_eq;
    logic             va_eq;
    logic             match;
    logic             op_illegal;

    assign op_illegal = (op > 5'd6);

    // Control FSM and request capture; start is only looked at in IDLE, so a
    // request arriving while busy is simply dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            idx    <= '0;
            op_q   <= '0;
            asid_q <= '0;
            vppn_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        asid_q <= asid;
                        vppn_q <= vppn;
                        ill_q  <= op_illegal;
                        idx    <= '0;
                        state  <= op_illegal ? S_DONE : S_WALK;
                    end
                end
                S_WALK: begin
                    // idx wraps to 0 on the same edge the walk ends
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign walk    = (state == S_WALK);
    assign asid_eq = (r_asid == asid_q);
    // 4 KB pages compare the full VPPN; larger pages only the upper bits
    assign va_eq   = (r_ps == 6'd12) ? (r_vppn == vppn_q)
                                     : (r_vppn[18:9] == vppn_q[18:9]);

    // Per-op match on the entry currently presented by the read port
    always_comb begin
        match = 1'b0;
        case (op_q)
            5'd0, 5'd1: match = 1'b1;
            5'd2:       match = r_g;
            5'd3:       match = !r_g;
            5'd4:       match = !r_g && asid_eq;
            5'd5:       match = !r_g && asid_eq && va_eq;
            5'd6:       match = (r_g || asid_eq) && va_eq;
            default:    match = 1'b0;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = done && ill_q;
    assign r_index   = walk ? idx : '0;
    assign inv_index = walk ? idx : '0;
    assign inv_we    = walk && r_e && match;

endmodule

// File: tb/tb_tlb_inv_ctrl.sv
// Directed bench for tlb_inv_ctrl with a small behavioural TLB array behind
// the read/invalidate ports.
module tb_tlb_inv_ctrl;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [4:0]       op = '0;
    logic [9:0]       asid = '0;
    logic [18:0]      vppn = '0;
    logic             busy, done, err, inv_we;
    logic [IDX_W-1:0] r_index, inv_index;
    logic             r_e, r_g;
    logic [5:0]       r_ps;
    logic [9:0]       r_asid;
    logic [18:0]      r_vppn;

    logic        tlb_e    [TLBNUM];
    logic        tlb_g    [TLBNUM];
    logic [5:0]  tlb_ps   [TLBNUM];
    logic [9:0]  tlb_asid [TLBNUM];
    logic [18:0] tlb_vppn [TLBNUM];

    int checks = 0;
    int errors = 0;

    tlb_inv_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .asid(asid),
        .vppn(vppn), .busy(busy), .done(done), .err(err), .r_index(r_index),
        .r_e(r_e), .r_g(r_g), .r_ps(r_ps), .r_asid(r_asid), .r_vppn(r_vppn),
        .inv_we(inv_we), .inv_index(inv_index)
    );

    always #5 clk = ~clk;

    assign r_e    = tlb_e[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_ps   = tlb_ps[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_vppn = tlb_vppn[r_index];

    always @(posedge clk) if (inv_we) tlb_e[inv_index] <= 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tlb();
        for (int i = 0; i < TLBNUM; i++) begin
            tlb_e[i] = 1'b0; tlb_g[i] = 1'b0; tlb_ps[i] = 6'd12;
            tlb_asid[i] = '0; tlb_vppn[i] = '0;
        end
    endtask

    task automatic set_ent(input int i, input logic g, input logic [5:0] ps,
                           input logic [9:0] a, input logic [18:0] v);
        tlb_e[i] = 1'b1; tlb_g[i] = g; tlb_ps[i] = ps; tlb_asid[i] = a; tlb_vppn[i] = v;
    endtask

    function automatic logic [15:0] e_mask();
        logic [15:0] m = '0;
        for (int i = 0; i < TLBNUM; i++) m[i] = tlb_e[i];
        return m;
    endfunction

    // Legal-op walk: checks index sequencing, done timing and the set of
    // entries written. restart_at>0 pulses a stray start in that WALK cycle.
    task automatic run(input string tag, input logic [4:0] o, input logic [9:0] a,
                       input logic [18:0] v, input logic [15:0] exp_mask, input int restart_at);
        logic [15:0] mask = '0;
        int ndone = 0;
        @(negedge clk);
        op = o; asid = a; vppn = v; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= TLBNUM + 3; c++) begin
            @(negedge clk);
            if (c == restart_at + 1 && restart_at > 0) start = 1'b0;
            if (done) ndone++;
            if (inv_we) mask[inv_index] = 1'b1;
            if (c <= TLBNUM) begin
                chk({tag, ".busy"}, busy, 1'b1);
                chk({tag, ".r_index"}, r_index, c - 1);
                chk({tag, ".inv_index"}, inv_index, c - 1);
                chk({tag, ".done_early"}, done, 1'b0);
            end else if (c == TLBNUM + 1) begin
                chk({tag, ".done"}, done, 1'b1);
                chk({tag, ".err"}, err, 1'b0);
                chk({tag, ".we_in_done"}, inv_we, 1'b0);
            end else begin
                chk({tag, ".idle_busy"}, busy, 1'b0);
            end
            if (c == restart_at) begin
                op = 5'd7; start = 1'b1;
            end
        end
        chk({tag, ".mask"}, mask, exp_mask);
        chk({tag, ".ndone"}, ndone, 1);
    endtask

    initial begin
        clear_tlb();
        // Reset state
        #2;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.inv_we", inv_we, 1'b0);
        chk("rst.r_index", r_index, 0);
        chk("rst.inv_index", inv_index, 0);
        @(negedge clk);
        resetn = 1'b1;

        // op 0 invalidates everything
        for (int i = 0; i < TLBNUM; i++) set_ent(i, 1'b0, 6'd12, 10'h0, 19'h0);
        run("op0", 5'd0, 10'h0, 19'h0, 16'hFFFF, 0);
        chk("op0.e_after", e_mask(), 16'h0000);

        // global vs ASID-scoped invalidation
        clear_tlb();
        set_ent(3, 1'b1, 6'd12, 10'h000, 19'h0);
        set_ent(7, 1'b0, 6'd12, 10'h005, 19'h0);
        run("op2", 5'd2, 10'h0, 19'h0, 16'h0008, 0);
        set_ent(3, 1'b1, 6'd12, 10'h000, 19'h0);
        run("op4", 5'd4, 10'h005, 19'h0, 16'h0080, 0);
        chk("op4.e_after", e_mask(), 16'h0008);

        // VA match, ps=21: 0x121FF differs from 0x12345 in bit 9, 0x122FF does not
        clear_tlb();
        set_ent(9, 1'b0, 6'd21, 10'h001, 19'h12345);
        run("op5_ps21_miss", 5'd5, 10'h001, 19'h121FF, 16'h0000, 0);
        run("op5_ps21_hit", 5'd5, 10'h001, 19'h122FF, 16'h0200, 0);
        set_ent(9, 1'b0, 6'd12, 10'h001, 19'h12345);
        run("op5_ps12", 5'd5, 10'h001, 19'h122FF, 16'h0000, 0);
        run("op5_asid", 5'd5, 10'h002, 19'h12345, 16'h0000, 0);
        set_ent(4, 1'b1, 6'd12, 10'h3FF, 19'h12345);
        run("op6", 5'd6, 10'h001, 19'h12345, 16'h0210, 0);

        // Illegal op
        clear_tlb();
        for (int i = 0; i < TLBNUM; i++) set_ent(i, 1'b0, 6'd12, 10'h0, 19'h0);
        @(negedge clk);
        op = 5'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("ill.done", done, 1'b1);
        chk("ill.err", err, 1'b1);
        chk("ill.we1", inv_we, 1'b0);
        @(negedge clk);
        chk("ill.busy2", busy, 1'b0);
        chk("ill.err2", err, 1'b0);
        chk("ill.e_after", e_mask(), 16'hFFFF);

        // Stray start mid-walk is ignored
        run("restart", 5'd0, 10'h0, 19'h0, 16'hFFFF, 5);
        start = 1'b0;

        // Reset at WALK cycle 8 aborts the walk
        for (int i = 0; i < TLBNUM; i++) set_ent(i, 1'b0, 6'd12, 10'h0, 19'h0);
        @(negedge clk);
        op = 5'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort.pre_idx", r_index, 7);
        resetn = 1'b0;
        #1;
        chk("abort.busy", busy, 1'b0);
        chk("abort.we", inv_we, 1'b0);
        chk("abort.r_index", r_index, 0);
        chk("abort.inv_index", inv_index, 0);
        begin
            int nd = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done || err) nd++;
            end
            chk("abort.no_done", nd, 0);
        end
        chk("abort.e_after", e_mask(), 16'hFF80);
        resetn = 1'b1;
        run("post_rst_op3", 5'd3, 10'h0, 19'h0, 16'hFF80, 0);
        chk("post_rst.e_after", e_mask(), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule
